// File: rtl/mem_access_pkg.sv
// Shared state encoding and default widths for mem_access_ctrl.
package mem_access_pkg;

    localparam int AW_DEF    = 4;
    localparam int DW_DEF    = 4;
    localparam int DEPTH_DEF = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE_W = 3'd1,
        ISSUE_R = 3'd2,
        WAIT    = 3'd3,
        RESP    = 3'd4,
        CLEAR   = 3'd5
    } state_e;

endpackage

// File: rtl/mem_access_ctrl.sv
// Single-word request/response front end driving the 16x4 storage array pins.
// Zero-sweep clear sequencer is built only when MEM_ACCESS_CTRL_CLEAR_EN is defined.
module mem_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    input  logic          clr_start,
    output logic          busy,
    output logic          mem_cs,
    output logic          mem_wrt,
    output logic          mem_rd,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    state_e        state_q, state_d;
    logic          accept_s;
    logic [AW-1:0] lat_addr_q, lat_addr_d;
    logic [DW-1:0] lat_wdata_q, lat_wdata_d;
    logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;

    logic          req_ready_q, req_ready_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          busy_q, busy_d;
    logic          mem_cs_q, mem_cs_d;
    logic          mem_wrt_q, mem_wrt_d;
    logic          mem_rd_q, mem_rd_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;

`ifdef MEM_ACCESS_CTRL_CLEAR_EN
    localparam int            DEPTH_M1 = DEPTH - 32'sd1;
    localparam logic [AW-1:0] CLR_LAST = AW'(DEPTH_M1);
    logic [AW-1:0] clr_cnt_q, clr_cnt_d;
`else
    logic unused_clr_start_s;
    assign unused_clr_start_s = clr_start;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; req_ready_q gates IDLE so nothing is taken in the first cycle after reset.
    always_comb begin
        state_d  = state_q;
        accept_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (!req_ready_q) begin
                    state_d = IDLE;
`ifdef MEM_ACCESS_CTRL_CLEAR_EN
                end else if (clr_start) begin
                    state_d = CLEAR;
`endif
                end else if (req_valid) begin
                    accept_s = 1'b1;
                    state_d  = req_we ? ISSUE_W : ISSUE_R;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE_W: state_d = IDLE;
            ISSUE_R: state_d = WAIT;
            WAIT:    state_d = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            CLEAR: begin
`ifdef MEM_ACCESS_CTRL_CLEAR_EN
                if (clr_cnt_q == CLR_LAST) begin
                    state_d = IDLE;
                end else begin
                    state_d = CLEAR;
                end
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // Request latch, read-data capture and clear address counter.
    always_comb begin
        if (accept_s) begin
            lat_addr_d  = req_addr;
            lat_wdata_d = req_wdata;
        end else begin
            lat_addr_d  = lat_addr_q;
            lat_wdata_d = lat_wdata_q;
        end
        if (state_q == WAIT) begin
            rsp_rdata_d = mem_rdata;
        end else begin
            rsp_rdata_d = rsp_rdata_q;
        end
`ifdef MEM_ACCESS_CTRL_CLEAR_EN
        if ((state_q == CLEAR) && (clr_cnt_q != CLR_LAST)) begin
            clr_cnt_d = clr_cnt_q + {{(AW-1){1'b0}}, 1'b1};
        end else begin
            clr_cnt_d = {AW{1'b0}};
        end
`endif
    end

    // Outputs are decoded from the next state so that they come straight off flops.
    always_comb begin
        req_ready_d = 1'b0;
        rsp_valid_d = 1'b0;
        busy_d      = 1'b1;
        mem_cs_d    = 1'b0;
        mem_wrt_d   = 1'b0;
        mem_rd_d    = 1'b0;
        mem_addr_d  = {AW{1'b0}};
        mem_wdata_d = {DW{1'b0}};
        case (state_d)
            IDLE: begin
                req_ready_d = 1'b1;
                busy_d      = 1'b0;
            end
            ISSUE_W: begin
                mem_cs_d    = 1'b1;
                mem_wrt_d   = 1'b1;
                mem_addr_d  = lat_addr_d;
                mem_wdata_d = lat_wdata_d;
            end
            ISSUE_R, WAIT: begin
                mem_cs_d   = 1'b1;
                mem_rd_d   = 1'b1;
                mem_addr_d = lat_addr_d;
            end
            RESP: begin
                rsp_valid_d = 1'b1;
            end
            CLEAR: begin
`ifdef MEM_ACCESS_CTRL_CLEAR_EN
                mem_cs_d   = 1'b1;
                mem_wrt_d  = 1'b1;
                mem_addr_d = clr_cnt_d;
`else
                busy_d = 1'b0;
`endif
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // Datapath and output registers; reset drops every strobe immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_addr_q  <= {AW{1'b0}};
            lat_wdata_q <= {DW{1'b0}};
            rsp_rdata_q <= {DW{1'b0}};
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            mem_cs_q    <= 1'b0;
            mem_wrt_q   <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_addr_q  <= {AW{1'b0}};
            mem_wdata_q <= {DW{1'b0}};
        end else begin
            lat_addr_q  <= lat_addr_d;
            lat_wdata_q <= lat_wdata_d;
            rsp_rdata_q <= rsp_rdata_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
            mem_cs_q    <= mem_cs_d;
            mem_wrt_q   <= mem_wrt_d;
            mem_rd_q    <= mem_rd_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

`ifdef MEM_ACCESS_CTRL_CLEAR_EN
    // Clear counter; an interrupted sweep restarts from address 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_cnt_q <= {AW{1'b0}};
        end else begin
            clr_cnt_q <= clr_cnt_d;
        end
    end
`endif

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign busy      = busy_q;
    assign mem_cs    = mem_cs_q;
    assign mem_wrt   = mem_wrt_q;
    assign mem_rd    = mem_rd_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: transaction-level reference model plus directed pins.
module tb_mem_access_ctrl;

    localparam int AW    = 4;
    localparam int DW    = 4;
    localparam int DEPTH = 16;
`ifdef MEM_ACCESS_CTRL_CLEAR_EN
    localparam bit CLR_EN = 1'b1;
`else
    localparam bit CLR_EN = 1'b0;
`endif

    localparam int OP_IDLE = 0;
    localparam int OP_WR   = 1;
    localparam int OP_RD   = 2;
    localparam int OP_CL   = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic          clr_start = 1'b0;
    logic          busy;
    logic          mem_cs, mem_wrt, mem_rd;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    always #5 clk = ~clk;

    mem_access_ctrl #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .clr_start(clr_start), .busy(busy),
        .mem_cs(mem_cs), .mem_wrt(mem_wrt), .mem_rd(mem_rd),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Storage array: synchronous write, registered read.
    logic [DW-1:0] arr [DEPTH];
    always @(posedge clk) begin
        if (mem_cs && mem_wrt) arr[mem_addr] <= mem_wdata;
        if (mem_cs && mem_rd)  mem_rdata <= arr[mem_addr];
    end

    // Reference model: current operation and cycles elapsed since it began.
    int            m_op = OP_IDLE;
    int            m_k  = 0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_data = '0;
    bit            m_acc = 1'b0;
    logic [DW-1:0] ref_mem [DEPTH];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic check_model();
        bit            e_idle, e_cs, e_wrt, e_rd, e_rv;
        logic [AW-1:0] e_addr;
        e_idle = (m_op == OP_IDLE);
        e_wrt  = (m_op == OP_WR && m_k == 1) || (m_op == OP_CL);
        e_rd   = (m_op == OP_RD && m_k <= 2);
        e_cs   = e_wrt || e_rd;
        e_rv   = (m_op == OP_RD && m_k >= 3);
        e_addr = (m_op == OP_CL) ? AW'(m_k - 1) : m_addr;
        chk("req_ready", req_ready, e_idle);
        chk("busy", busy, !e_idle);
        chk("mem_cs", mem_cs, e_cs);
        chk("mem_wrt", mem_wrt, e_wrt);
        chk("mem_rd", mem_rd, e_rd);
        chk("rsp_valid", rsp_valid, e_rv);
        if (e_cs)   chk("mem_addr", mem_addr, e_addr);
        if (e_wrt)  chk("mem_wdata", mem_wdata, (m_op == OP_CL) ? '0 : m_data);
        if (e_idle) chk("idle_addr", mem_addr, 0);
        if (e_idle) chk("idle_wdata", mem_wdata, 0);
        if (e_rv)   chk("rsp_rdata", rsp_rdata, m_data);
    endtask

    task automatic advance();
        m_acc = 1'b0;
        case (m_op)
            OP_IDLE: begin
                if (CLR_EN && clr_start) begin
                    m_op = OP_CL;
                    m_k  = 1;
                end else if (req_valid) begin
                    m_acc  = 1'b1;
                    m_addr = req_addr;
                    m_k    = 1;
                    if (req_we) begin
                        m_op   = OP_WR;
                        m_data = req_wdata;
                    end else begin
                        m_op   = OP_RD;
                        m_data = ref_mem[req_addr];
                    end
                end
            end
            OP_WR: begin
                ref_mem[m_addr] = m_data;
                m_op = OP_IDLE;
            end
            OP_RD: begin
                if (m_k < 3) m_k++;
                else if (rsp_ready) m_op = OP_IDLE;
            end
            OP_CL: begin
                ref_mem[m_k - 1] = '0;
                if (m_k == DEPTH) m_op = OP_IDLE;
                else m_k++;
            end
            default: m_op = OP_IDLE;
        endcase
    endtask

    // One cycle: check the cycle's outputs, drive its inputs, step the model.
    task automatic step(input bit v, input bit we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input bit c, input bit rr);
        @(negedge clk);
        check_model();
        req_valid = v; req_we = we; req_addr = a; req_wdata = d;
        clr_start = c; rsp_ready = rr;
        advance();
    endtask

    task automatic idle1();
        step(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        req_valid = 1'b0; clr_start = 1'b0; rsp_ready = 1'b0;
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_strobes", {mem_cs, mem_wrt, mem_rd}, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_rdata", rsp_rdata, 0);
        m_op = OP_IDLE;
        m_k  = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic write_w(input logic [AW-1:0] a, input logic [DW-1:0] d);
        step(1'b1, 1'b1, a, d, 1'b0, 1'b0);
        idle1();
    endtask

    task automatic read_lit(input logic [AW-1:0] a, input logic [DW-1:0] e);
        step(1'b1, 1'b0, a, 4'h0, 1'b0, 1'b1);
        idle1();
        idle1();
        idle1();
        chk("lit_rd_valid", rsp_valid, 1);
        chk("lit_rd_data", rsp_rdata, e);
        idle1();
    endtask

    bit            pv = 1'b0;
    bit            pwe = 1'b0;
    logic [AW-1:0] pa = '0;
    logic [DW-1:0] pd = '0;

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        reset_dut();

        for (int i = 0; i < DEPTH; i++) write_w(AW'(i), DW'($urandom_range(0, 15)));

        // Write 0xB to address 9: one strobe cycle, then ready again.
        step(1'b1, 1'b1, 4'h9, 4'hB, 1'b0, 1'b0);
        chk("lit_w_ready_acc", req_ready, 1);
        idle1();
        chk("lit_w_wrt", mem_wrt, 1);
        chk("lit_w_addr", mem_addr, 4'h9);
        chk("lit_w_data", mem_wdata, 4'hB);
        chk("lit_w_ready", req_ready, 0);
        idle1();
        chk("lit_w_wrt_off", mem_wrt, 0);
        chk("lit_w_ready_back", req_ready, 1);

        // Read back address 9: rsp_valid exactly three cycles after accept.
        step(1'b1, 1'b0, 4'h9, 4'h0, 1'b0, 1'b1);
        idle1();
        chk("lit_r_valid_n1", rsp_valid, 0);
        idle1();
        chk("lit_r_valid_n2", rsp_valid, 0);
        idle1();
        chk("lit_r_valid_n3", rsp_valid, 1);
        chk("lit_r_data", rsp_rdata, 4'hB);
        idle1();
        chk("lit_r_ready_back", req_ready, 1);

        // Back-pressured read of address 5.
        write_w(4'h5, 4'h6);
        step(1'b1, 1'b0, 4'h5, 4'h0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 4'h1, 4'h1, 1'b0, 1'b0);
            chk("lit_bp_valid", rsp_valid, 1);
            chk("lit_bp_data", rsp_rdata, 4'h6);
            chk("lit_bp_ready", req_ready, 0);
        end
        step(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
        chk("lit_bp_hs_valid", rsp_valid, 1);
        idle1();
        chk("lit_bp_idle_ready", req_ready, 1);
        chk("lit_bp_idle_busy", busy, 0);

`ifdef MEM_ACCESS_CTRL_CLEAR_EN
        // Full sweep after two writes.
        write_w(4'hB, 4'h3);
        write_w(4'h5, 4'hF);
        step(1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            idle1();
            chk("lit_clr_wrt", mem_wrt, 1);
            chk("lit_clr_addr", mem_addr, i);
            chk("lit_clr_data", mem_wdata, 0);
            chk("lit_clr_busy", busy, 1);
        end
        idle1();
        chk("lit_clr_done", busy, 0);
        read_lit(4'hB, 4'h0);
        read_lit(4'h5, 4'h0);

        // Clear and request together: clear first, request held then accepted.
        write_w(4'h3, 4'h9);
        step(1'b1, 1'b0, 4'h3, 4'h0, 1'b1, 1'b1);
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 1'b0, 4'h3, 4'h0, 1'b0, 1'b1);
            chk("lit_cw_ready", req_ready, 0);
        end
        step(1'b1, 1'b0, 4'h3, 4'h0, 1'b0, 1'b1);
        chk("lit_cw_ready_after", req_ready, 1);
        idle1();
        idle1();
        idle1();
        chk("lit_cw_valid", rsp_valid, 1);
        chk("lit_cw_data", rsp_rdata, 4'h0);
        idle1();

        // Reset during a sweep: no resume, only the swept addresses are zero.
        write_w(4'h2, 4'h7);
        write_w(4'hC, 4'h7);
        step(1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) idle1();
        reset_dut();
        idle1();
        chk("lit_rc_idle", busy, 0);
        read_lit(4'h2, 4'h0);
        read_lit(4'hC, 4'h7);
`else
        // Clear request ignored in this build.
        step(1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            idle1();
            chk("lit_noclr_cs", mem_cs, 0);
            chk("lit_noclr_busy", busy, 0);
        end
`endif

        // Reset in the middle of a read.
        step(1'b1, 1'b0, 4'h9, 4'h0, 1'b0, 1'b1);
        idle1();
        reset_dut();

        // Randomized traffic; the master holds a request until it is taken.
        for (int i = 0; i < 3000; i++) begin
            if (!pv && ($urandom_range(0, 99) < 45)) begin
                pv  = 1'b1;
                pwe = 1'($urandom_range(0, 1));
                pa  = AW'($urandom_range(0, DEPTH - 1));
                pd  = DW'($urandom_range(0, 15));
            end
            step(pv, pwe, pa, pd, ($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 60));
            if (m_acc) pv = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
